// File: rtl/p_i_cache_line_fill_responder_pkg.sv
// Shared definitions for the cache line-fill responders (I-cache and D-cache).
// Fill FSM state encoding, line/beat geometry and the line-alignment helper.
package p_i_cache_line_fill_responder_pkg;

   localparam int S_OFFSET   = 5;
   localparam int S_LINE     = 256;
   localparam int S_BEAT     = 64;
   localparam int NUM_BEATS  = 4;
   localparam int BEAT_IDX_W = 2;

   localparam logic [BEAT_IDX_W-1:0] LAST_BEAT = 2'd3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      DONE = 2'd2
   } fill_state_e;

   // Clear the line-offset bits so the burst always starts on a line boundary
   function automatic logic [31:0] line_align(input logic [31:0] addr);
      return {addr[31:S_OFFSET], {S_OFFSET{1'b0}}};
   endfunction

endpackage

// File: rtl/p_i_cache_line_fill_responder_line_fill_buffer.sv
// Line buffer: NUM_BEATS x S_BEAT registers written one beat at a time by index,
// presented as one flat line with beat i at bits [64i+63:64i].
module p_i_cache_line_fill_responder_line_fill_buffer
   import p_i_cache_line_fill_responder_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  we,
   input  logic [BEAT_IDX_W-1:0] idx,
   input  logic [S_BEAT-1:0]     wdata,
   output logic [S_LINE-1:0]     line
);

   logic [S_BEAT-1:0] slot_r [NUM_BEATS];

   // Capture the incoming beat into its slot; reset empties the whole line
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_BEATS; i++) begin
            slot_r[i] <= '0;
         end
      end else if (we) begin
         slot_r[idx] <= wdata;
      end
   end

   // Flatten the slots into the line in beat order
   always_comb begin
      line = '0;
      for (int i = 0; i < NUM_BEATS; i++) begin
         line[i*S_BEAT +: S_BEAT] = slot_r[i];
      end
   end

endmodule

// File: rtl/p_i_cache_line_fill_responder.sv
// Memory-side responder for the I-cache line fill: one 4-beat burst per request,
// beats assembled into a line buffer, line returned with a single-cycle pmem_resp.
module p_i_cache_line_fill_responder
   import p_i_cache_line_fill_responder_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              pmem_read,
   input  logic [31:0]       pmem_address,
   output logic [S_LINE-1:0] pmem_rdata,
   output logic              pmem_resp,
   output logic              burst_read,
   output logic [31:0]       burst_address,
   input  logic [S_BEAT-1:0] burst_rdata,
   input  logic              burst_resp,
   output logic              busy
);

   fill_state_e           state_r;
   fill_state_e           state_s;
   logic [BEAT_IDX_W-1:0] cnt_r;
   logic [31:0]           addr_r;
   logic                  beat_we_s;
   logic                  pmem_resp_r;
   logic                  burst_read_r;
   logic                  busy_r;

   // Next-state decode; beats are only accepted while the burst is in flight
   always_comb begin
      state_s   = state_r;
      beat_we_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (pmem_read) begin
               state_s = READ;
            end else begin
               state_s = IDLE;
            end
         end
         READ: begin
            if (burst_resp) begin
               beat_we_s = 1'b1;
               if (cnt_r == LAST_BEAT) begin
                  state_s = DONE;
               end else begin
                  state_s = READ;
               end
            end else begin
               state_s = READ;
            end
         end
         DONE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Fill FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Latch the aligned address at request time and count accepted beats
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_r <= 32'h0000_0000;
         cnt_r  <= '0;
      end else if ((state_r == IDLE) && pmem_read) begin
         addr_r <= line_align(pmem_address);
         cnt_r  <= '0;
      end else if (beat_we_s) begin
         cnt_r <= cnt_r + 2'd1;
      end
   end

   // Outputs registered from the next state so they line up with the state they describe
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pmem_resp_r  <= 1'b0;
         burst_read_r <= 1'b0;
         busy_r       <= 1'b0;
      end else begin
         pmem_resp_r  <= (state_s == DONE);
         burst_read_r <= (state_s == READ);
         busy_r       <= (state_s != IDLE);
      end
   end

   p_i_cache_line_fill_responder_line_fill_buffer u_line_buf (
      .clk   (clk),
      .rst_n (rst),
      .we    (beat_we_s),
      .idx   (cnt_r),
      .wdata (burst_rdata),
      .line  (pmem_rdata)
   );

   assign pmem_resp     = pmem_resp_r;
   assign burst_read    = burst_read_r;
   assign burst_address = addr_r;
   assign busy          = busy_r;

endmodule

// File: tb/tb_p_i_cache_line_fill_responder.sv
// Directed bench for the I-cache line-fill responder.
module tb_p_i_cache_line_fill_responder;

   logic         clk = 1'b0;
   logic         rst;
   logic         pmem_read;
   logic [31:0]  pmem_address;
   logic [255:0] pmem_rdata;
   logic         pmem_resp;
   logic         burst_read;
   logic [31:0]  burst_address;
   logic [63:0]  burst_rdata;
   logic         burst_resp;
   logic         busy;

   int checks   = 0;
   int failures = 0;

   // Observations gathered while driving a fill
   logic [31:0]  ba_first;
   int           ba_changes;
   int           br_low;
   int           busy_low;
   int           resp_early;
   logic         resp_at_done;
   logic         br_at_done;
   logic         busy_at_done;
   logic [255:0] line_at_done;

   localparam logic [255:0] L1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                  64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
   localparam logic [255:0] L2 = {64'hD0D0_D0D0_D0D0_D0D0, 64'hC0C0_C0C0_C0C0_C0C0,
                                  64'hB0B0_B0B0_B0B0_B0B0, 64'hA0A0_A0A0_A0A0_A0A0};
   localparam logic [255:0] L3 = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                                  64'h0F0F_0F0F_F0F0_F0F0, 64'h5A5A_A5A5_5A5A_A5A5};
   localparam logic [255:0] L4 = {64'h8888_0000_8888_0001, 64'h7777_0000_7777_0002,
                                  64'h6666_0000_6666_0003, 64'h5555_0000_5555_0004};
   localparam logic [63:0]  GARB = 64'hBADB_ADBA_DBAD_BAD0;

   p_i_cache_line_fill_responder dut (
      .clk           (clk),
      .rst           (rst),
      .pmem_read     (pmem_read),
      .pmem_address  (pmem_address),
      .pmem_rdata    (pmem_rdata),
      .pmem_resp     (pmem_resp),
      .burst_read    (burst_read),
      .burst_address (burst_address),
      .burst_rdata   (burst_rdata),
      .burst_resp    (burst_resp),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic observe();
      if (burst_address !== ba_first) ba_changes++;
      if (burst_read !== 1'b1) br_low++;
      if (busy !== 1'b1) busy_low++;
      if (pmem_resp !== 1'b0) resp_early++;
   endtask

   // Drive one fill from an IDLE cycle up to the cycle where pmem_resp is due
   task automatic fill(input logic [31:0] addr, input int waits, input logic [255:0] line, input bit chg);
      pmem_read    = 1'b1;
      pmem_address = addr;
      burst_resp   = 1'b0;
      step();
      ba_first   = burst_address;
      ba_changes = 0;
      br_low     = 0;
      busy_low   = 0;
      resp_early = 0;
      for (int b = 0; b < 4; b++) begin
         for (int w = 0; w < ((b == 0) ? 0 : waits); w++) begin
            observe();
            burst_resp = 1'b0;
            step();
         end
         observe();
         burst_resp  = 1'b1;
         burst_rdata = line[64*b +: 64];
         step();
         burst_resp = 1'b0;
         if (chg && (b == 0)) pmem_address = 32'hDEAD_BEE0;
      end
      resp_at_done = pmem_resp;
      br_at_done   = burst_read;
      busy_at_done = busy;
      line_at_done = pmem_rdata;
   endtask

   task automatic test_reset();
      rst = 1'b0; pmem_read = 1'b0; pmem_address = 32'h0; burst_rdata = 64'h0; burst_resp = 1'b0;
      #1;
      checks++; if (pmem_resp !== 1'b0) begin failures++; $display("FAIL rst_pmem_resp got=%b exp=0", pmem_resp); end
      checks++; if (burst_read !== 1'b0) begin failures++; $display("FAIL rst_burst_read got=%b exp=0", burst_read); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
      checks++; if (burst_address !== 32'h0) begin failures++; $display("FAIL rst_burst_address got=%h exp=0", burst_address); end
      checks++; if (pmem_rdata !== 256'h0) begin failures++; $display("FAIL rst_pmem_rdata got=%h exp=0", pmem_rdata); end
      step(); step();
      rst = 1'b1;
      step();
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL post_rst_busy got=%b exp=0", busy); end
   endtask

   task automatic test_zero_wait();
      fill(32'h0000_1234, 0, L1, 1'b0);
      checks++; if (ba_first !== 32'h0000_1220) begin failures++; $display("FAIL zw_burst_address got=%h exp=00001220", ba_first); end
      checks++; if (br_low !== 0) begin failures++; $display("FAIL zw_burst_read_low got=%0d exp=0", br_low); end
      checks++; if (busy_low !== 0) begin failures++; $display("FAIL zw_busy_low got=%0d exp=0", busy_low); end
      checks++; if (resp_early !== 0) begin failures++; $display("FAIL zw_resp_early got=%0d exp=0", resp_early); end
      checks++; if (resp_at_done !== 1'b1) begin failures++; $display("FAIL zw_resp_t5 got=%b exp=1", resp_at_done); end
      checks++; if (br_at_done !== 1'b0) begin failures++; $display("FAIL zw_done_burst_read got=%b exp=0", br_at_done); end
      checks++; if (busy_at_done !== 1'b1) begin failures++; $display("FAIL zw_done_busy got=%b exp=1", busy_at_done); end
      checks++; if (line_at_done !== L1) begin failures++; $display("FAIL zw_line got=%h exp=%h", line_at_done, L1); end
      pmem_read = 1'b0;
      step();
      checks++; if (pmem_resp !== 1'b0) begin failures++; $display("FAIL zw_resp_single got=%b exp=0", pmem_resp); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL zw_idle_busy got=%b exp=0", busy); end
      checks++; if (pmem_rdata !== L1) begin failures++; $display("FAIL zw_line_hold got=%h exp=%h", pmem_rdata, L1); end
   endtask

   task automatic test_wait_states();
      fill(32'h0000_1234, 2, L2, 1'b0);
      checks++; if (ba_first !== 32'h0000_1220) begin failures++; $display("FAIL ws_burst_address got=%h exp=00001220", ba_first); end
      checks++; if (ba_changes !== 0) begin failures++; $display("FAIL ws_address_stable got=%0d exp=0", ba_changes); end
      checks++; if (br_low !== 0) begin failures++; $display("FAIL ws_burst_read_low got=%0d exp=0", br_low); end
      checks++; if (resp_early !== 0) begin failures++; $display("FAIL ws_resp_early got=%0d exp=0", resp_early); end
      checks++; if (resp_at_done !== 1'b1) begin failures++; $display("FAIL ws_resp got=%b exp=1", resp_at_done); end
      checks++; if (line_at_done !== L2) begin failures++; $display("FAIL ws_line got=%h exp=%h", line_at_done, L2); end
      pmem_read = 1'b0;
      step();
      checks++; if (pmem_resp !== 1'b0) begin failures++; $display("FAIL ws_resp_single got=%b exp=0", pmem_resp); end
   endtask

   task automatic test_addr_change();
      fill(32'h0000_1234, 0, L1, 1'b1);
      checks++; if (ba_first !== 32'h0000_1220) begin failures++; $display("FAIL ac_burst_address got=%h exp=00001220", ba_first); end
      checks++; if (ba_changes !== 0) begin failures++; $display("FAIL ac_address_stable got=%0d exp=0", ba_changes); end
      checks++; if (burst_address !== 32'h0000_1220) begin failures++; $display("FAIL ac_latched_addr got=%h exp=00001220", burst_address); end
      checks++; if (line_at_done !== L1) begin failures++; $display("FAIL ac_line got=%h exp=%h", line_at_done, L1); end
      pmem_read = 1'b0;
      step();
   endtask

   task automatic test_reset_mid_burst();
      pmem_read = 1'b1; pmem_address = 32'h0000_1234;
      step();
      burst_resp = 1'b1; burst_rdata = 64'h5555_5555_5555_5555;
      step();
      burst_rdata = 64'h6666_6666_6666_6666;
      step();
      burst_resp = 1'b0;
      rst = 1'b0;
      #1;
      checks++; if (burst_read !== 1'b0) begin failures++; $display("FAIL mr_burst_read got=%b exp=0", burst_read); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mr_busy got=%b exp=0", busy); end
      checks++; if (pmem_rdata !== 256'h0) begin failures++; $display("FAIL mr_pmem_rdata got=%h exp=0", pmem_rdata); end
      checks++; if (burst_address !== 32'h0) begin failures++; $display("FAIL mr_burst_address got=%h exp=0", burst_address); end
      pmem_read = 1'b0;
      step(); step();
      rst = 1'b1;
      step();
      fill(32'h0000_8000, 0, L3, 1'b0);
      checks++; if (ba_first !== 32'h0000_8000) begin failures++; $display("FAIL mr_new_address got=%h exp=00008000", ba_first); end
      checks++; if (resp_at_done !== 1'b1) begin failures++; $display("FAIL mr_new_resp got=%b exp=1", resp_at_done); end
      checks++; if (line_at_done !== L3) begin failures++; $display("FAIL mr_new_line got=%h exp=%h", line_at_done, L3); end
      pmem_read = 1'b0;
      step();
   endtask

   task automatic test_hold_through_done();
      fill(32'h0000_0100, 0, L3, 1'b0);
      checks++; if (resp_at_done !== 1'b1) begin failures++; $display("FAIL hd_first_resp got=%b exp=1", resp_at_done); end
      burst_resp = 1'b1; burst_rdata = GARB;
      step();
      checks++; if (pmem_resp !== 1'b0) begin failures++; $display("FAIL hd_idle_resp got=%b exp=0", pmem_resp); end
      checks++; if (burst_read !== 1'b0) begin failures++; $display("FAIL hd_idle_burst_read got=%b exp=0", burst_read); end
      checks++; if (pmem_rdata !== L3) begin failures++; $display("FAIL hd_done_beat_ignored got=%h exp=%h", pmem_rdata, L3); end
      step();
      checks++; if (burst_read !== 1'b1) begin failures++; $display("FAIL hd_second_burst got=%b exp=1", burst_read); end
      checks++; if (burst_address !== 32'h0000_0100) begin failures++; $display("FAIL hd_second_addr got=%h exp=00000100", burst_address); end
      checks++; if (pmem_rdata !== L3) begin failures++; $display("FAIL hd_idle_beat_ignored got=%h exp=%h", pmem_rdata, L3); end
      for (int b = 0; b < 4; b++) begin
         burst_resp  = 1'b1;
         burst_rdata = L4[64*b +: 64];
         step();
      end
      burst_resp = 1'b0;
      checks++; if (pmem_resp !== 1'b1) begin failures++; $display("FAIL hd_second_resp got=%b exp=1", pmem_resp); end
      checks++; if (pmem_rdata !== L4) begin failures++; $display("FAIL hd_second_line got=%h exp=%h", pmem_rdata, L4); end
      pmem_read = 1'b0;
      step();
   endtask

   task automatic test_back_to_back();
      fill(32'h0000_0100, 0, L1, 1'b0);
      checks++; if (busy_low !== 0) begin failures++; $display("FAIL bb_first_busy_low got=%0d exp=0", busy_low); end
      checks++; if (line_at_done !== L1) begin failures++; $display("FAIL bb_first_line got=%h exp=%h", line_at_done, L1); end
      pmem_read = 1'b0;
      step();
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bb_gap_busy got=%b exp=0", busy); end
      fill(32'h0000_0200, 0, L2, 1'b0);
      checks++; if (ba_first !== 32'h0000_0200) begin failures++; $display("FAIL bb_second_addr got=%h exp=00000200", ba_first); end
      checks++; if (busy_low !== 0) begin failures++; $display("FAIL bb_second_busy_low got=%0d exp=0", busy_low); end
      checks++; if (line_at_done !== L2) begin failures++; $display("FAIL bb_second_line got=%h exp=%h", line_at_done, L2); end
      pmem_read = 1'b0;
      step();
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bb_end_busy got=%b exp=0", busy); end
      burst_resp = 1'b1; burst_rdata = GARB;
      step(); step();
      burst_resp = 1'b0;
      checks++; if (pmem_rdata !== L2) begin failures++; $display("FAIL bb_idle_beat_ignored got=%h exp=%h", pmem_rdata, L2); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bb_idle_busy got=%b exp=0", busy); end
   endtask

   initial begin
      test_reset();
      test_zero_wait();
      test_wait_states();
      test_addr_change();
      test_reset_mid_burst();
      test_hold_through_done();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
